// File: rtl/ah_fifo_pkg.sv
// Shared definitions for the snoopable FIFO and its upstream issue stage:
// default sizes, issue-stage state encoding and the credit-counter width helper.
package ah_fifo_pkg;

  localparam int WIDTH_DEF   = 164;
  localparam int CREDITS_DEF = 48;

  // Smallest width that can hold the value n itself (0..n inclusive).
  function automatic int credit_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CW_DEF = credit_width(CREDITS_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } tx_state_e;

endpackage

// File: rtl/ah_credit_counter.sv
// Up/down credit counter starting full; an increment at full is dropped and
// raises a sticky error flag.
module ah_credit_counter
  import ah_fifo_pkg::*;
#(
  parameter int MAX = CREDITS_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          err_o
);

  localparam logic [CW-1:0] MaxVal = CW'(MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_q == MaxVal) err_d = 1'b1;
        else                 cnt_d = cnt_q + CW'(1);
      end
      2'b01: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= MaxVal;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: rtl/ah_snoop_credit_tx.sv
// Issue stage: holds one request, snoops the FIFO with it until clean, then
// issues it when a credit is available. One issue per cycle at most.
module ah_snoop_credit_tx
  import ah_fifo_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CREDITS = CREDITS_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] wdata,
  output logic             wvalid,
  input  logic             wcredit,
  output logic [WIDTH-1:0] sdata,
  output logic             svalid,
  input  logic             smatch,
  output logic [CW-1:0]    credit_cnt,
  output logic [15:0]      hazard_stalls,
  output logic             credit_err
);

  localparam logic [15:0] StallMax = 16'hFFFF;

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] wdata_q;
  logic             wvalid_q;
  logic [15:0]      stalls_q;
  logic             ready_c;
  logic             issue;
  logic             hazard;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ready_c = 1'b0;
    issue   = 1'b0;
    hazard  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (in_valid) begin
          hold_d  = in_data;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (smatch) begin
          hazard = 1'b1;
        end else if (credit_cnt != '0) begin
          issue   = 1'b1;
          ready_c = 1'b1;
          if (in_valid) hold_d  = in_data;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: the wide hold register is reset because sdata exposes it straight out of reset.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
      stalls_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      wvalid_q <= issue;
      if (issue) wdata_q <= hold_q;
      if (hazard && (stalls_q != StallMax)) stalls_q <= stalls_q + 16'd1;
    end
  end

  ah_credit_counter #(
    .MAX (CREDITS),
    .CW  (CW)
  ) u_credits (
    .clk   (clk),
    .rst   (rstn),
    .inc_i (wcredit),
    .dec_i (issue),
    .cnt_o (credit_cnt),
    .err_o (credit_err)
  );

  // Nothing may be accepted while reset holds the registers.
  assign in_ready      = ready_c & ~rstn;
  assign wdata         = wdata_q;
  assign wvalid        = wvalid_q;
  assign sdata         = hold_q;
  assign svalid        = (state_q == CHECK);
  assign hazard_stalls = stalls_q;

endmodule

// File: tb/tb_ah_snoop_credit_tx.sv
// Bench for ah_snoop_credit_tx: a 2-credit and a 48-credit instance share
// inputs; a queue-based reference model predicts every output each cycle.
module tb_ah_snoop_credit_tx;

  localparam int W  = 164;
  localparam int CW = 6;

  logic          clk;
  logic          rstn;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          wcredit;
  logic          smatch;

  logic          in_ready_a, wvalid_a, svalid_a, err_a;
  logic [W-1:0]  wdata_a, sdata_a;
  logic [CW-1:0] credit_a;
  logic [15:0]   stalls_a;

  logic          in_ready_b, wvalid_b, svalid_b, err_b;
  logic [W-1:0]  wdata_b, sdata_b;
  logic [CW-1:0] credit_b;
  logic [15:0]   stalls_b;

  ah_snoop_credit_tx #(.WIDTH(W), .CREDITS(2), .CW(CW)) dut (
    .clk (clk), .rstn (rstn), .in_data (in_data), .in_valid (in_valid),
    .in_ready (in_ready_a), .wdata (wdata_a), .wvalid (wvalid_a),
    .wcredit (wcredit), .sdata (sdata_a), .svalid (svalid_a),
    .smatch (smatch), .credit_cnt (credit_a), .hazard_stalls (stalls_a),
    .credit_err (err_a)
  );

  ah_snoop_credit_tx #(.WIDTH(W), .CREDITS(48), .CW(CW)) dut48 (
    .clk (clk), .rstn (rstn), .in_data (in_data), .in_valid (in_valid),
    .in_ready (in_ready_b), .wdata (wdata_b), .wvalid (wvalid_b),
    .wcredit (wcredit), .sdata (sdata_b), .svalid (svalid_b),
    .smatch (smatch), .credit_cnt (credit_b), .hazard_stalls (stalls_b),
    .credit_err (err_b)
  );

  // Selects which instance is being observed.
  logic          sel;
  logic          o_ready, o_wvalid, o_svalid, o_err;
  logic [W-1:0]  o_wdata, o_sdata;
  logic [CW-1:0] o_credit;
  logic [15:0]   o_stalls;

  assign o_ready  = sel ? in_ready_b : in_ready_a;
  assign o_wvalid = sel ? wvalid_b   : wvalid_a;
  assign o_svalid = sel ? svalid_b   : svalid_a;
  assign o_err    = sel ? err_b      : err_a;
  assign o_wdata  = sel ? wdata_b    : wdata_a;
  assign o_sdata  = sel ? sdata_b    : sdata_a;
  assign o_credit = sel ? credit_b   : credit_a;
  assign o_stalls = sel ? stalls_b   : stalls_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: words accepted but not yet issued, plus plain counters.
  logic [W-1:0] pend[$];
  logic [W-1:0] m_hold, m_wd;
  logic         m_wv, m_err;
  int           m_cred, m_stall, m_cap;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_hold  = '0;
    m_wd    = '0;
    m_wv    = 1'b0;
    m_err   = 1'b0;
    m_cred  = m_cap;
    m_stall = 0;
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Entered and left at posedge+1: drive, check, advance model, clock.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic sm,
                     input logic wc, output logic acc);
    logic busy, can_iss, exp_ready;
    int   nc;
    in_valid = v;
    in_data  = d;
    smatch   = sm;
    wcredit  = wc;
    #1;
    busy      = (pend.size() != 0);
    can_iss   = busy && !sm && (m_cred > 0);
    exp_ready = !busy || can_iss;
    check("svalid",        o_svalid, busy);
    check("in_ready",      o_ready,  exp_ready);
    check("sdata",         o_sdata,  m_hold);
    check("wvalid",        o_wvalid, m_wv);
    if (m_wv) check("wdata", o_wdata, m_wd);
    check("credit_cnt",    o_credit, m_cred);
    check("hazard_stalls", o_stalls, m_stall);
    check("credit_err",    o_err,    m_err);

    nc = m_cred - int'(can_iss) + int'(wc);
    if (nc > m_cap) begin
      nc    = m_cap;
      m_err = 1'b1;
    end
    m_cred = nc;
    if (busy && sm && m_stall < 65535) m_stall++;
    m_wv = can_iss;
    if (can_iss) m_wd = pend.pop_front();
    acc = v && exp_ready;
    if (acc) begin
      pend.push_back(d);
      m_hold = d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    in_valid = 1'b0;
    smatch   = 1'b0;
    wcredit  = 1'b0;
    rstn     = 1'b1;
    #1;
    check("rst_wvalid",  o_wvalid, 1'b0);
    check("rst_svalid",  o_svalid, 1'b0);
    check("rst_ready",   o_ready,  1'b0);
    check("rst_credit",  o_credit, m_cap);
    check("rst_stalls",  o_stalls, 0);
    check("rst_err",     o_err,    1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
  endtask

  initial begin
    logic acc;
    int   idx;
    sel      = 1'b0;
    m_cap    = 2;
    rstn     = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    smatch   = 1'b0;
    wcredit  = 1'b0;
    model_reset();
    #3;
    check("init_sdata",  o_sdata,  '0);
    check("init_credit", o_credit, 2);
    check("init_ready",  o_ready,  1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b0;

    // Single word: snoop on cycle 1, issue visible on cycle 2.
    cyc(1'b1, W'('hA5), 1'b0, 1'b0, acc);
    check("t1_svalid", o_svalid, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    check("t1_wvalid", o_wvalid, 1'b1);
    check("t1_wdata",  o_wdata,  W'('hA5));
    check("t1_credit", o_credit, 1);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);

    // Back-to-back words until credits run out, then a credit return.
    do_reset();
    cyc(1'b1, W'(1), 1'b0, 1'b0, acc);
    cyc(1'b1, W'(2), 1'b0, 1'b0, acc);
    cyc(1'b1, W'(3), 1'b0, 1'b0, acc);
    check("t2_credit0", o_credit, 0);
    check("t2_wdata2",  o_wdata,  W'(2));
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    check("t2_ready0",  o_ready,  1'b0);
    check("t2_held",    o_svalid, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    check("t2_wvalid3", o_wvalid, 1'b1);
    check("t2_wdata3",  o_wdata,  W'(3));
    cyc(1'b0, '0, 1'b0, 1'b0, acc);

    // Snoop hazard for four cycles.
    do_reset();
    cyc(1'b1, W'('h55), 1'b0, 1'b0, acc);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, acc);
    check("t3_stalls",  o_stalls, 4);
    check("t3_nowv",    o_wvalid, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    check("t3_wvalid",  o_wvalid, 1'b1);
    check("t3_wdata",   o_wdata,  W'('h55));
    cyc(1'b0, '0, 1'b0, 1'b0, acc);

    // Simultaneous issue and credit return, then surplus credits.
    do_reset();
    cyc(1'b1, W'('hB1), 1'b0, 1'b0, acc);
    cyc(1'b1, W'('hB2), 1'b0, 1'b0, acc);
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    check("t4_credit_same", o_credit, 1);
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    check("t4_credit_cap", o_credit, 2);
    check("t4_err",        o_err,    1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);

    // Reset while 0x77 is held with no credits and an issue in flight.
    do_reset();
    cyc(1'b1, W'('h10), 1'b0, 1'b0, acc);
    cyc(1'b1, W'('h20), 1'b0, 1'b0, acc);
    cyc(1'b1, W'('h77), 1'b0, 1'b0, acc);
    check("t5_credit0", o_credit, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b0, acc);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc($urandom_range(0, 3) != 0, rnd_word(), $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0, acc);
    end

    // Full-size instance: 48 issues exhaust credits, the 49th word stalls.
    sel   = 1'b1;
    m_cap = 48;
    do_reset();
    idx = 0;
    for (int i = 0; i < 52; i++) begin
      cyc(idx < 49, W'(idx + 1), 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check("t6_credit0", o_credit, 0);
    check("t6_stalls",  o_stalls, 0);
    check("t6_ready0",  o_ready,  1'b0);
    check("t6_held",    o_sdata,  W'(49));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ah_snoop_credit_tx.md
Name: ah_snoop_credit_tx

Overview:
- Upstream issue stage that feeds the 164-bit, 48-entry snoopable FIFO.
- Accepts requests over a valid/ready port and holds each one in a single holding register.
- Snoops the FIFO with the held word every cycle until no match is reported, then issues it into the FIFO.
- Issue is credit-based: one credit per free FIFO entry.

Parameters:
WIDTH, 164, data word width (matches FIFO wdata/sdata)
CREDITS, 48, initial credit count; equals FIFO depth
CW, 6, credit counter width; must satisfy 2^CW > CREDITS

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous, active-high reset (asserted = 1)
in_data  input  WIDTH  request word
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid & in_ready
wdata  output  WIDTH  word to FIFO
wvalid  output  1  one-cycle issue pulse to FIFO
wcredit  input  1  one-cycle pulse from FIFO: one entry freed
sdata  output  WIDTH  snoop word to FIFO
svalid  output  1  snoop request
smatch  input  1  combinational FIFO response: sdata matches a resident entry
credit_cnt  output  CW  current credits
hazard_stalls  output  16  saturating count of cycles stalled on smatch
credit_err  output  1  sticky: wcredit received while credit_cnt == CREDITS

Behaviour:
- Reset (rstn=1, asynchronous):
  - state=IDLE; hold register = 0; wdata=0; wvalid=0.
  - credit_cnt=CREDITS; hazard_stalls=0; credit_err=0.
  - in_ready is forced to 0 while rstn=1.
- Outputs sdata and svalid:
  - sdata = hold register at all times.
  - svalid = (state==CHECK).
- State IDLE:
  - in_ready=1.
  - in_valid=1 -> capture in_data into hold, go to CHECK.
- State CHECK (evaluated each cycle):
  - smatch=1 -> hazard. Stay in CHECK, in_ready=0, hazard_stalls++ (saturates at 0xFFFF). Re-snoop next cycle, since FIFO contents change.
  - smatch=0 and credit_cnt==0 -> stay in CHECK, in_ready=0. No hazard count.
  - smatch=0 and credit_cnt>0 -> issue:
    - at the clock edge: wdata<=hold, wvalid<=1 for exactly one cycle.
    - in_ready=1 in this cycle.
    - if in_valid=1, capture the new word into hold and stay in CHECK (back-to-back, one issue per cycle); otherwise go to IDLE.
- wvalid/wdata are registered. Issue latency from first clean snoop cycle to wvalid is 1 cycle; from in_valid acceptance to the earliest wvalid is 2 cycles.
- credit_cnt, updated at the clock edge:
  - issue only -> -1
  - wcredit only -> +1
  - issue and wcredit in the same cycle -> unchanged
  - credit_cnt==0 with wcredit in the same cycle -> no issue this cycle; count becomes 1.
  - wcredit while credit_cnt==CREDITS and no issue -> count held at CREDITS, credit_err<=1 (sticky until reset).
- Ordering: words are issued strictly in acceptance order. A word is never dropped or duplicated.
- Reset mid-operation: the held word is discarded, all credits are restored, and any in-flight wvalid is cleared asynchronously.

Decomposition:
- Shared package ah_fifo_pkg:
  - WIDTH and CREDITS defaults
  - state encoding: IDLE=1'b0, CHECK=1'b1
  - credit-counter width helper constant
- Sub-module ah_credit_counter (up/down counter with saturation and error flag), reused by the FIFO's read side.

Test Plan (CREDITS=2 unless noted):
- Reset, then in_valid=1 with in_data=0xA5, smatch=0 -> svalid=1 on cycle 1; wvalid=1 with wdata=0xA5 on cycle 2; credit_cnt goes 2 -> 1.
- Three back-to-back words 0x1,0x2,0x3, no wcredit -> 0x1 and 0x2 issue on consecutive cycles; 0x3 holds in CHECK with in_ready=0 and credit_cnt=0; a wcredit pulse -> 0x3 issues the next cycle.
- Word 0x55 with smatch=1 held for 4 cycles -> hazard_stalls=4, no wvalid during the hazard; wvalid with wdata=0x55 in the cycle after smatch drops.
- credit_cnt=1, issue and wcredit in the same cycle -> credit_cnt stays 1; then two extra wcredit pulses at credit_cnt=2 -> credit_cnt stays 2, credit_err=1.
- rstn pulsed while 0x77 is held in CHECK with credit_cnt=0 -> immediately state=IDLE, wvalid=0, credit_cnt=2; 0x77 is never issued after reset.
- CREDITS=48: 48 issues with no wcredit -> 49th word stalls; hazard_stalls unchanged by the credit stall.
